add_rstation: RTL
=================

# add_rstation

Three-entry reservation station for the add/sub functional unit. It sits directly downstream of the issue stage and accepts one renamed add/sub instruction per cycle, with operands given as values or ROB tags. It captures results broadcast on the common data bus (CDB) and dispatches the oldest fully-ready entry to the adder under a valid/ready handshake. Occupancy is exported so issue can stall when the station is full.

## Interface
Parameters:
- DEPTH, 3: number of entries; occupancy width is $clog2(DEPTH+1).
- DW, 16: operand/result data width.
- TW, 3: ROB tag width (ROB has 8 slots).

Ports:
- clk1  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  issue presents an add/sub instruction.
- alloc_ready  out  1  at least one free entry (registered state only).
- alloc_func  in  4  4'b0000 add, 4'b0001 sub.
- alloc_dest  in  TW  ROB index of the instruction.
- alloc_vj, alloc_vk  in  DW  operand values, meaningful when the matching q*_busy is 0.
- alloc_qj, alloc_qk  in  TW  producing ROB tag.
- alloc_qj_busy, alloc_qk_busy  in  1  operand still pending.
- cdb_valid  in  1  result broadcast this cycle.
- cdb_tag  in  TW  ROB tag of broadcast result.
- cdb_data  in  DW  broadcast result value.
- disp_valid  out  1  a ready entry is offered to the adder.
- disp_ready  in  1  adder accepts.
- disp_func  out  4  function of offered entry.
- disp_a, disp_b  out  DW  operands (j, k).
- disp_dest  out  TW  ROB tag of offered entry.
- flush  in  1  synchronous clear of all entries (mispredict).
- occupancy  out  2  busy entry count, 0..3.

## Operation
- Per-entry state: busy, func, dest, vj, vk, qj, qk, qj_busy, qk_busy, age (2 bits).
- Allocation fires on alloc_valid && alloc_ready && func ∈ {0000, 0001}. Any other func is ignored: no entry is taken and no state changes. The lowest-index free entry is written.
- Same-cycle CDB bypass on allocation: if cdb_valid and cdb_tag == alloc_qj with alloc_qj_busy=1, the entry stores vj=cdb_data and qj_busy=0. The k operand follows the same rule.
- Wakeup: each busy entry with q*_busy=1 and q* == cdb_tag under cdb_valid captures cdb_data and clears q*_busy. Both operands may wake on one broadcast.
- Ready condition: busy && !qj_busy && !qk_busy, computed from registered state only. A woken entry is eligible the cycle after wakeup, never in the same cycle.
- Selection is combinational. disp_* presents the ready entry with the smallest age. Ages are unique among busy entries.
- Age bookkeeping:
  - On dispatch, busy entries with age greater than the leaver's age decrement.
  - A new entry gets age = busy count after the leaver is removed.
- Dispatch fires on disp_valid && disp_ready; the selected entry is freed at the edge.
- disp_* outputs hold stable while disp_valid=1 && disp_ready=0, unless a strictly older entry becomes ready, in which case the selection switches to it.
- flush clears every busy bit and has priority over alloc, wakeup and dispatch in that cycle.
- Width rules: values pass through unmodified; no arithmetic is performed on data. The occupancy update is computed as +1/−1/0 and never leaves 0..3.

## Timing
- Reset values: all busy=0, occupancy=0, alloc_ready=1, disp_valid=0, disp_func=0, disp_a=0, disp_b=0, disp_dest=0.
- Minimum latency is 1 cycle: an entry allocated at edge N with both operands ready can dispatch in the cycle after edge N.
- Wakeup-to-dispatch: broadcast at edge N, disp_valid asserted after edge N.
- Full with simultaneous dispatch: alloc_ready=0 (no pass-through). The freed slot becomes available the next cycle.
- Simultaneous alloc and dispatch when not full: both occur; occupancy is unchanged.
- Empty with alloc: disp_valid stays 0 in the allocation cycle.
- rst asserted mid-operation returns all state to reset values immediately. In-flight disp handshakes are dropped.

## Structure
- Shared package (tomasulo_pkg): func codes FUNC_ADD=4'b0000, FUNC_SUB=4'b0001, FUNC_MUL, FUNC_DIV; DW and TW; an rs_entry_t struct.
- One natural sub-module, rs_age_select: given ready and age vectors, it outputs a one-hot grant and the selected index. It is purely combinational.
- The rest (entries, wakeup, bookkeeping) lives in add_rstation.

## Test plan
- Basic: alloc add, vj=5, vk=7, both ready → next cycle disp_valid=1, disp_a=5, disp_b=7, disp_func=0000; with disp_ready=1, occupancy returns to 0.
- Wakeup: alloc sub, qj=3 busy, vk=2. cdb(tag=3, data=10) two cycles later → disp_a=10, disp_b=2 one cycle after the broadcast, and not before.
- Bypass: alloc with qk=5 busy in the same cycle as cdb(tag=5, data=0xBEEF) → entry ready the next cycle, disp_b=0xBEEF.
- Age order: alloc A (tag 1, pending), B (tag 2, ready), C (tag 4, ready), with disp_ready=0. Wake A → B offered first, then A and C in age order A before C.
- Full: 3 allocs, no dispatch → alloc_ready=0, occupancy=3, a 4th alloc is ignored. Dispatch and alloc in the same cycle → alloc still blocked; accepted the next cycle.
- Flush/reset: 2 busy entries, assert flush together with alloc and cdb → occupancy=0, disp_valid=0 next cycle. Repeat with async rst pulsed mid-cycle → outputs at reset values immediately.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: function codes, datapath widths and the
// reservation-station entry layout used by the add/sub station.
package tomasulo_pkg;

    localparam int DW    = 16;
    localparam int TW    = 3;
    localparam int AGE_W = 2;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef struct packed {
        logic             busy;
        logic [3:0]       func;
        logic [TW-1:0]    dest;
        logic [DW-1:0]    vj;
        logic [DW-1:0]    vk;
        logic [TW-1:0]    qj;
        logic [TW-1:0]    qk;
        logic             qj_busy;
        logic             qk_busy;
        logic [AGE_W-1:0] age;
    } rs_entry_t;

    function automatic logic is_addsub_func(input logic [3:0] f);
        return (f == FUNC_ADD) || (f == FUNC_SUB);
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry with the smallest age.
// Purely combinational; ages of ready entries are assumed unique.
module rs_age_select
    import tomasulo_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = AGE_W,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         ready,
    input  logic [N-1:0][AW-1:0] age,
    output logic [N-1:0]         grant,
    output logic [IW-1:0]        sel_idx,
    output logic                 any_ready
);

    logic [AW-1:0] best_age;

    always_comb begin
        grant     = '0;
        sel_idx   = '0;
        any_ready = 1'b0;
        best_age  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!any_ready || (age[i] < best_age))) begin
                any_ready  = 1'b1;
                best_age   = age[i];
                grant      = '0;
                grant[i]   = 1'b1;
                sel_idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/add_rstation.sv
// Add/sub reservation station: allocates renamed instructions, captures CDB
// results, and offers the oldest fully-ready entry to the adder.
module add_rstation
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int DW    = 16,
    parameter int TW    = 3
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [3:0]                 alloc_func,
    input  logic [TW-1:0]              alloc_dest,
    input  logic [DW-1:0]              alloc_vj,
    input  logic [DW-1:0]              alloc_vk,
    input  logic [TW-1:0]              alloc_qj,
    input  logic [TW-1:0]              alloc_qk,
    input  logic                       alloc_qj_busy,
    input  logic                       alloc_qk_busy,
    input  logic                       cdb_valid,
    input  logic [TW-1:0]              cdb_tag,
    input  logic [DW-1:0]              cdb_data,
    output logic                       disp_valid,
    input  logic                       disp_ready,
    output logic [3:0]                 disp_func,
    output logic [DW-1:0]              disp_a,
    output logic [DW-1:0]              disp_b,
    output logic [TW-1:0]              disp_dest,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t [DEPTH-1:0]            entry_q, entry_d;
    logic [OW-1:0]                    occupancy_q, occupancy_d;
    logic [DEPTH-1:0]                 ready_vec, grant, free_oh;
    logic [DEPTH-1:0][AGE_W-1:0]      age_vec;
    logic [IW-1:0]                    sel_idx;
    logic                             any_ready, free_found;
    logic                             alloc_fire, disp_fire;
    logic [AGE_W-1:0]                 leave_age;
    rs_entry_t                        new_entry;

    always_comb begin
        ready_vec  = '0;
        age_vec    = '0;
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entry_q[i].busy && !entry_q[i].qj_busy && !entry_q[i].qk_busy;
            age_vec[i]   = entry_q[i].age;
            if (!entry_q[i].busy && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    rs_age_select #(.N(DEPTH), .AW(AGE_W), .IW(IW)) u_select (
        .ready     (ready_vec),
        .age       (age_vec),
        .grant     (grant),
        .sel_idx   (sel_idx),
        .any_ready (any_ready)
    );

    // Outputs come only from registered state, so a fresh wakeup or
    // allocation never becomes visible in the same cycle.
    always_comb begin
        alloc_ready = (occupancy_q != OW'(DEPTH));
        disp_valid  = any_ready;
        disp_func   = any_ready ? entry_q[sel_idx].func : '0;
        disp_a      = any_ready ? entry_q[sel_idx].vj   : '0;
        disp_b      = any_ready ? entry_q[sel_idx].vk   : '0;
        disp_dest   = any_ready ? entry_q[sel_idx].dest : '0;
        leave_age   = entry_q[sel_idx].age;
        occupancy   = occupancy_q;
        disp_fire   = any_ready && disp_ready;
        alloc_fire  = alloc_valid && alloc_ready && is_addsub_func(alloc_func);
    end

    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.func    = alloc_func;
        new_entry.dest    = alloc_dest;
        new_entry.vj      = alloc_vj;
        new_entry.vk      = alloc_vk;
        new_entry.qj      = alloc_qj;
        new_entry.qk      = alloc_qk;
        new_entry.qj_busy = alloc_qj_busy;
        new_entry.qk_busy = alloc_qk_busy;
        new_entry.age     = AGE_W'(occupancy_q - OW'(disp_fire));
        if (alloc_qj_busy && cdb_valid && (cdb_tag == alloc_qj)) begin
            new_entry.vj      = cdb_data;
            new_entry.qj_busy = 1'b0;
        end
        if (alloc_qk_busy && cdb_valid && (cdb_tag == alloc_qk)) begin
            new_entry.vk      = cdb_data;
            new_entry.qk_busy = 1'b0;
        end
    end

    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].busy) begin
                if (cdb_valid && entry_q[i].qj_busy && (entry_q[i].qj == cdb_tag)) begin
                    entry_d[i].vj      = cdb_data;
                    entry_d[i].qj_busy = 1'b0;
                end
                if (cdb_valid && entry_q[i].qk_busy && (entry_q[i].qk == cdb_tag)) begin
                    entry_d[i].vk      = cdb_data;
                    entry_d[i].qk_busy = 1'b0;
                end
                if (disp_fire && (entry_q[i].age > leave_age)) begin
                    entry_d[i].age = entry_q[i].age - AGE_W'(1);
                end
                if (disp_fire && grant[i]) begin
                    entry_d[i].busy = 1'b0;
                end
            end
            if (alloc_fire && free_oh[i]) begin
                entry_d[i] = new_entry;
            end
            if (flush) begin
                entry_d[i].busy = 1'b0;
            end
        end
        if (flush) begin
            occupancy_d = '0;
        end else begin
            occupancy_d = occupancy_q + OW'(alloc_fire) - OW'(disp_fire);
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            entry_q     <= '0;
            occupancy_q <= '0;
        end else begin
            entry_q     <= entry_d;
            occupancy_q <= occupancy_d;
        end
    end

endmodule
